// File: rtl/mapper_pkg.sv
// Shared types and helpers for the ASCII8/ASCII16 bank-switch mapper.
package mapper_pkg;

    typedef logic [24:0] mem_addr_t;

    localparam logic [15:0] REG_BASE = 16'h6000;
    localparam logic [15:0] WIN_BASE = 16'h4000;

    // Window number of a CPU address inside 0x4000-0xBFFF; meaningless outside it.
    function automatic logic [1:0] win_index(input logic [15:0] addr, input int page_bits);
        logic [15:0] off;
        off = addr - WIN_BASE;
        return 2'(off >> page_bits);
    endfunction

endpackage

// File: rtl/mapper_ascii_banked.sv
// ASCII8/ASCII16 cartridge bank-switch mapper: CPU window -> 25-bit linear address.
// Optional battery SRAM overlay is enabled with MAPPER_SRAM_EN.
module mapper_ascii_banked
    import mapper_pkg::*;
#(
    parameter int        PAGE_BITS   = 13,
    parameter int        BANK_W      = 8,
    parameter mem_addr_t SRAM_BASE   = 25'h100000,
    parameter int        SRAM_BITS   = 13,
    parameter bit        INIT_LINEAR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        din,
    input  logic              cpu_mreq,
    input  logic              cpu_wr,
    input  logic              cs,
    input  logic [BANK_W-1:0] bank_mask,
    output mem_addr_t         mem_addr,
    output logic              mem_unmaped,
    output logic              sram_cs,
    output logic              sram_we
);

    localparam int WIN_W = 15 - PAGE_BITS;
    localparam int NWIN  = 1 << WIN_W;

    logic [BANK_W-1:0] bank [NWIN];
    logic              wr_req_d;
    logic              in_window;
    logic              reg_hit;
    logic [WIN_W-1:0]  win;
    logic [WIN_W-1:0]  reg_idx;
    logic              wr_req;
    logic              commit;
    logic              sram_hit;
    logic [BANK_W-1:0] bank_rom;
    logic [BANK_W-1:0] din_bank;
    mem_addr_t         rom_addr;
    mem_addr_t         sram_addr;

    assign in_window = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);
    assign win       = WIN_W'(win_index(cpu_addr, PAGE_BITS));
    assign reg_hit   = (cpu_addr[15:13] == REG_BASE[15:13]);
    assign reg_idx   = cpu_addr[12 -: WIN_W];

`ifdef MAPPER_SRAM_EN
    logic [NWIN-1:0] sram_sel;

    assign sram_hit = cs & cpu_mreq & in_window & sram_sel[win];
    assign bank_rom = {1'b0, bank[win][BANK_W-2:0]};
    assign din_bank = {1'b0, din[BANK_W-2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_sel <= '0;
        end else if (commit) begin
            sram_sel[reg_idx] <= din[BANK_W-1];
        end
    end
`else
    assign sram_hit = 1'b0;
    assign bank_rom = bank[win];
    assign din_bank = din[BANK_W-1:0];
`endif

    // Only the upper half of the windows (0x8000-0xBFFF) accepts SRAM writes.
    assign sram_we = sram_hit & cpu_wr & win[WIN_W-1];
    assign sram_cs = sram_hit;

    assign wr_req = cs & cpu_mreq & cpu_wr & reg_hit & ~sram_we;
    assign commit = wr_req & ~wr_req_d;

    // wr_req_d keeps tracking the strobe through reset, so a write still held
    // when reset releases is seen as already in progress and never commits.
    always_ff @(posedge clk) begin
        wr_req_d <= wr_req;
        if (reset) begin
            for (int i = 0; i < NWIN; i++) begin
                bank[i] <= INIT_LINEAR ? BANK_W'(i) : '0;
            end
        end else if (commit) begin
            bank[reg_idx] <= din_bank;
        end
    end

    assign rom_addr    = mem_addr_t'({bank_rom & bank_mask, cpu_addr[PAGE_BITS-1:0]});
    assign sram_addr   = SRAM_BASE + mem_addr_t'(cpu_addr[SRAM_BITS-1:0]);
    assign mem_addr    = sram_hit ? sram_addr : rom_addr;
    assign mem_unmaped = cs & ~in_window;

endmodule

// File: tb/tb_mapper_ascii_banked.sv
// Bench for mapper_ascii_banked: an 8 KB instance (INIT_LINEAR=0) and a 16 KB instance
// (INIT_LINEAR=1) share one CPU bus; directed vectors, corner sequences, random traffic.
module tb_mapper_ascii_banked;
    import mapper_pkg::*;

    localparam int SRAM_BASE_I = 'h100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  din;
    logic        cpu_mreq;
    logic        cpu_wr;
    logic        cs;
    logic [7:0]  bank_mask;
    mem_addr_t   mem_addr8, mem_addr16;
    logic        unm8, unm16, scs8, scs16, swe8, swe16;

    int n_tests = 0;
    int n_fail  = 0;

    mapper_ascii_banked #(.PAGE_BITS(13), .INIT_LINEAR(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .din(din), .cpu_mreq(cpu_mreq),
        .cpu_wr(cpu_wr), .cs(cs), .bank_mask(bank_mask), .mem_addr(mem_addr8),
        .mem_unmaped(unm8), .sram_cs(scs8), .sram_we(swe8)
    );

    mapper_ascii_banked #(.PAGE_BITS(14), .INIT_LINEAR(1'b1)) u_dut16 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .din(din), .cpu_mreq(cpu_mreq),
        .cpu_wr(cpu_wr), .cs(cs), .bank_mask(bank_mask), .mem_addr(mem_addr16),
        .mem_unmaped(unm16), .sram_cs(scs16), .sram_we(swe16)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (index 0 = 8 KB, 1 = 16 KB) ----------------
    int bank_m [2][4];
    bit ssel_m [2][4];

    function automatic int pbits(input int d);
        return (d != 0) ? 14 : 13;
    endfunction

    function automatic int nwin(input int d);
        return 32768 >> pbits(d);
    endfunction

    function automatic bit in_win(input int a);
        return (a >= 'h4000) && (a < 'hC000);
    endfunction

    function automatic int win_of(input int d, input int a);
        return (a - 'h4000) / (1 << pbits(d));
    endfunction

    function automatic bit exp_scs(input int d, input int a, input bit c, input bit m);
`ifdef MAPPER_SRAM_EN
        return c && m && in_win(a) && ssel_m[d][win_of(d, a)];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_swe(input int d, input int a, input bit c, input bit m, input bit w);
        return exp_scs(d, a, c, m) && w && (win_of(d, a) >= nwin(d) / 2);
    endfunction

    function automatic int exp_mem(input int d, input int a, input bit c, input bit m);
        int ps;
        ps = 1 << pbits(d);
        if (exp_scs(d, a, c, m)) return SRAM_BASE_I + (a % 8192);
        return (bank_m[d][win_of(d, a)] & int'(bank_mask)) * ps + (a % ps);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                bank_m[d][i] = (d != 0) ? i : 0;
                ssel_m[d][i] = 1'b0;
            end
        end
    endtask

    // One write transaction = one fresh strobe edge; data is that of the first cycle.
    task automatic model_write(input int a, input int dt, input bit c, input bit m);
        int idx;
        for (int d = 0; d < 2; d++) begin
            if (c && m && a >= 'h6000 && a < 'h8000 && !exp_swe(d, a, c, m, 1'b1)) begin
                idx = (a - 'h6000) >> (pbits(d) - 2);
`ifdef MAPPER_SRAM_EN
                bank_m[d][idx] = dt & 'h7F;
                ssel_m[d][idx] = dt[7];
`else
                bank_m[d][idx] = dt;
`endif
            end
        end
    endtask

    // ---------------- checking and bus helpers ----------------
    task automatic check_out(input string name, input int d, input bit chk_mem, input int exp_m,
                             input bit exp_u, input bit exp_c, input bit exp_w);
        mem_addr_t am;
        logic u, c, w;
        am = (d != 0) ? mem_addr16 : mem_addr8;
        u  = (d != 0) ? unm16 : unm8;
        c  = (d != 0) ? scs16 : scs8;
        w  = (d != 0) ? swe16 : swe8;
        if (chk_mem) begin
            n_tests++;
            if (am !== mem_addr_t'(exp_m)) begin
                n_fail++;
                $display("FAIL %s dut%0d addr=%h mem_addr got %h want %h", name, d, cpu_addr, am, mem_addr_t'(exp_m));
            end
        end
        n_tests++;
        if ({u, c, w} !== {exp_u, exp_c, exp_w}) begin
            n_fail++;
            $display("FAIL %s dut%0d addr=%h {unmaped,sram_cs,sram_we} got %b%b%b want %b%b%b",
                     name, d, cpu_addr, u, c, w, exp_u, exp_c, exp_w);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                             input int hold, input bit c, input bit m);
        @(negedge clk);
        cpu_addr = a; din = d0; cs = c; cpu_mreq = m; cpu_wr = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            check_out("wr_strobe", d, in_win(a), exp_mem(d, a, c, m), c && !in_win(a),
                      exp_scs(d, a, c, m), exp_swe(d, a, c, m, 1'b1));
        end
        model_write(a, d0, c, m);
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            din = d1;
        end
        @(negedge clk);
        cpu_wr = 1'b0; cs = 1'b0; cpu_mreq = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input bit c, input bit m);
        @(negedge clk);
        cpu_addr = a; cs = c; cpu_mreq = m; cpu_wr = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check_out("rand_rd", d, in_win(a), exp_mem(d, a, c, m), c && !in_win(a),
                      exp_scs(d, a, c, m), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        bit          cs;
        bit          mreq;
        logic [7:0]  din;
        logic [7:0]  din_late;
        int          hold;
        int          sel;
        bit          chk_mem;
        int          exp_mem;
        bit          exp_unm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t wr_v(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1,
                                  input int hold, input bit c, input bit m);
        vec_t v;
        v = '{1'b1, a, c, m, d0, d1, hold, 0, 1'b0, 0, 1'b0};
        return v;
    endfunction

    function automatic vec_t rd_v(input logic [15:0] a, input bit c, input int sel,
                                  input bit chk, input int em, input bit eu);
        vec_t v;
        v = '{1'b0, a, c, 1'b1, 8'h00, 8'h00, 0, sel, chk, em, eu};
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c, m;
        logic [15:0] a;
        logic [7:0] masks [3];

        reset = 1'b1; cpu_addr = 16'h0000; din = 8'h00; cpu_mreq = 1'b0; cpu_wr = 1'b0; cs = 1'b0;
        bank_mask = 8'h3F;
        masks[0] = 8'h03; masks[1] = 8'h3F; masks[2] = 8'hFF;

        vecs.push_back(rd_v(16'h4123, 1'b1, 0, 1'b1, 'h00123, 1'b0));
        vecs.push_back(rd_v(16'hA123, 1'b1, 0, 1'b1, 'h00123, 1'b0));
        vecs.push_back(rd_v(16'h8000, 1'b1, 1, 1'b1, 'h04000, 1'b0));
        vecs.push_back(rd_v(16'hC000, 1'b1, 0, 1'b0, 0, 1'b1));
        vecs.push_back(rd_v(16'h2000, 1'b1, 1, 1'b0, 0, 1'b1));
        vecs.push_back(rd_v(16'hC000, 1'b0, 0, 1'b0, 0, 1'b0));
        vecs.push_back(wr_v(16'h6800, 8'h15, 8'h15, 1, 1'b1, 1'b1));
        vecs.push_back(rd_v(16'h6010, 1'b1, 0, 1'b1, 'h2A010, 1'b0));
        vecs.push_back(rd_v(16'h4005, 1'b1, 1, 1'b1, 'h54005, 1'b0));
        vecs.push_back(wr_v(16'h7000, 8'h55, 8'h55, 1, 1'b1, 1'b1));
        vecs.push_back(rd_v(16'h8000, 1'b1, 0, 1'b1, 'h2A000, 1'b0));
        vecs.push_back(rd_v(16'h8001, 1'b1, 1, 1'b1, 'h54001, 1'b0));
        vecs.push_back(wr_v(16'h7800, 8'h02, 8'h03, 5, 1'b1, 1'b1));
        vecs.push_back(rd_v(16'hA123, 1'b1, 0, 1'b1, 'h04123, 1'b0));
        vecs.push_back(rd_v(16'hBFFF, 1'b1, 1, 1'b1, 'h0BFFF, 1'b0));
        vecs.push_back(wr_v(16'h7000, 8'h07, 8'h07, 1, 1'b1, 1'b1));
        vecs.push_back(rd_v(16'h8001, 1'b1, 1, 1'b1, 'h1C001, 1'b0));
        vecs.push_back(rd_v(16'h8001, 1'b1, 0, 1'b1, 'h0E001, 1'b0));
        vecs.push_back(rd_v(16'hC000, 1'b1, 1, 1'b0, 0, 1'b1));
        vecs.push_back(wr_v(16'h6000, 8'h33, 8'h33, 1, 1'b0, 1'b1));
        vecs.push_back(wr_v(16'h6000, 8'h34, 8'h34, 1, 1'b1, 1'b0));
        vecs.push_back(wr_v(16'hC000, 8'h11, 8'h11, 2, 1'b1, 1'b1));
        vecs.push_back(rd_v(16'h4000, 1'b1, 0, 1'b1, 'h00000, 1'b0));
        vecs.push_back(rd_v(16'h4000, 1'b1, 1, 1'b1, 'h54000, 1'b0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                bus_write(vecs[i].addr, vecs[i].din, vecs[i].din_late, vecs[i].hold,
                          vecs[i].cs, vecs[i].mreq);
            end else begin
                @(negedge clk);
                cpu_addr = vecs[i].addr; cs = vecs[i].cs; cpu_mreq = vecs[i].mreq; cpu_wr = 1'b0;
                #2;
                check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].chk_mem, vecs[i].exp_mem,
                          vecs[i].exp_unm, 1'b0, 1'b0);
            end
        end

        // Reset asserted under a held register write: no commit after release.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cpu_addr = 16'h6000; din = 8'h2C; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        din = 8'h3D;
        @(negedge clk);
        cpu_wr = 1'b0; cs = 1'b0; cpu_mreq = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h4000; cs = 1'b1; cpu_mreq = 1'b1;
        #2;
        check_out("rst_held_wr_8k", 0, 1'b1, 'h00000, 1'b0, 1'b0, 1'b0);
        check_out("rst_held_wr_16k", 1, 1'b1, 'h00000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cpu_addr = 16'h8000;
        #2;
        check_out("rst_linear_16k", 1, 1'b1, 'h04000, 1'b0, 1'b0, 1'b0);
        bus_write(16'h6000, 8'h09, 8'h09, 2, 1'b1, 1'b1);
        @(negedge clk);
        cpu_addr = 16'h4000; cs = 1'b1; cpu_mreq = 1'b1;
        #2;
        check_out("fresh_edge_8k", 0, 1'b1, 'h12000, 1'b0, 1'b0, 1'b0);
        check_out("fresh_edge_16k", 1, 1'b1, 'h24000, 1'b0, 1'b0, 1'b0);

`ifdef MAPPER_SRAM_EN
        bus_write(16'h7000, 8'h80, 8'h80, 1, 1'b1, 1'b1);
        @(negedge clk);
        cpu_addr = 16'h8010; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b0;
        #2;
        check_out("sram_rd_8k", 0, 1'b1, 'h100010, 1'b0, 1'b1, 1'b0);
        check_out("sram_rd_16k", 1, 1'b1, 'h100010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cpu_wr = 1'b1; din = 8'h01;
        #2;
        check_out("sram_wr_hi_8k", 0, 1'b1, 'h100010, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        cpu_wr = 1'b0;
        #2;
        check_out("sram_reg2_kept", 0, 1'b1, 'h100010, 1'b0, 1'b1, 1'b0);
        bus_write(16'h6000, 8'h80, 8'h80, 1, 1'b1, 1'b1);
        @(negedge clk);
        cpu_addr = 16'h4010; cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1; din = 8'h02;
        #2;
        check_out("sram_wr_lo_8k", 0, 1'b1, 'h100010, 1'b0, 1'b1, 1'b0);
        check_out("sram_wr_lo_16k", 1, 1'b1, 'h100010, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cpu_wr = 1'b0; cs = 1'b0; cpu_mreq = 1'b0;
`endif

        // Random traffic against the model, one ROM size per round.
        for (int r = 0; r < 3; r++) begin
            bank_mask = masks[r];
            do_reset();
            for (int t = 0; t < 150; t++) begin
                if ($urandom_range(0, 9) < 4) a = 16'h6000 + 16'($urandom_range(0, 'h1FFF));
                else                          a = 16'($urandom_range(0, 'hFFFF));
                c = ($urandom_range(0, 7) != 0);
                m = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 1) == 1)
                    bus_write(a, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                              int'($urandom_range(1, 4)), c, m);
                else
                    bus_read(a, c, m);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
